// File: rtl/life_row_engine_pkg.sv
// life_row_engine_pkg: default rule masks, frame geometry and mode encoding shared by the Life row engine
package life_row_engine_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SEEDING, CLEARING} mode_e;
    localparam logic [8:0] BIRTH_B3    = 9'b000001000;
    localparam logic [8:0] SURVIVE_S23 = 9'b000001100;
    localparam int         LINES_DEF   = 480;
    localparam int         ARM_ROW_DEF = 481;
endpackage

// File: rtl/life_row_engine_if.sv
// life_row_engine_if: scan, window, rule and fill-control signals between the row engine and its neighbours
interface life_row_engine_if #(parameter int WIDTH = 640, COL_W = 10, ROW_W = 9);
    logic             noise, reading, display_active, wrap_edges, freeze;
    logic             seed_request, clear_request, busy;
    logic [WIDTH-1:0] read_row, draw_row, write_row;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] column;
    logic [8:0]       birth_mask, survive_mask;
    logic [7:0]       density;
    logic [COL_W:0]   row_pop;
    modport master (
        output noise, reading, read_row, display_active, row, column, wrap_edges,
               birth_mask, survive_mask, freeze, seed_request, clear_request, density,
        input  draw_row, write_row, busy, row_pop
    );
    modport slave (
        input  noise, reading, read_row, display_active, row, column, wrap_edges,
               birth_mask, survive_mask, freeze, seed_request, clear_request, density,
        output draw_row, write_row, busy, row_pop
    );
endinterface

// File: rtl/life_row_engine_random.sv
// Random: 16-bit Fibonacci LFSR with the external noise bit folded into its feedback
module Random (
    input  logic        clkDiv,
    input  logic        rst,
    input  logic        noise_i,
    output logic [15:0] random_o
);
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10] ^ noise_i};
    assign random_o = lfsr_q;
    always_ff @(posedge clkDiv or posedge rst)
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
endmodule

// File: rtl/life_row_engine.sv
// life_row_engine: three-row Life window that writes the next generation one column per pixel clock
module life_row_engine
    import life_row_engine_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int COL_W   = 10,
    parameter int ROW_W   = 9,
    parameter int LINES   = LINES_DEF,
    parameter int ARM_ROW = ARM_ROW_DEF
) (
    input logic              clkDiv,
    input logic              rst,
    life_row_engine_if.slave bus_io
);
    typedef logic [(1 << COL_W)-1:0] ext_t;
    mode_e            state_q, state_d;
    logic             clear_kind_q, clear_kind_d, reading_q;
    logic [WIDTH-1:0] above_q, above_d, centre_q, centre_d, write_q, write_d, oh;
    logic [3:0]       count_q, count_d;
    logic [COL_W:0]   pop_q, pop_d;
    logic [COL_W-1:0] col, nxt_col;
    logic [15:0]      rand_w;
    logic [7:0]       unused_rand_hi, nb;
    logic             load, active, wrap, cur, wbit;

    function automatic logic pick(input logic [WIDTH-1:0] r, input logic [COL_W-1:0] i);
        ext_t e;
        e = ext_t'(r);
        return e[i];
    endfunction
    // Shifted copies line each left/right neighbour up with the target column
    function automatic logic [WIDTH-1:0] from_left(input logic [WIDTH-1:0] r, input logic w);
        return {r[WIDTH-2:0], w & r[WIDTH-1]};
    endfunction
    function automatic logic [WIDTH-1:0] from_right(input logic [WIDTH-1:0] r, input logic w);
        return {w & r[0], r[WIDTH-1:1]};
    endfunction

    Random u_random (.clkDiv(clkDiv), .rst(rst), .noise_i(bus_io.noise), .random_o(rand_w));
    assign unused_rand_hi = rand_w[15:8];

    always_comb begin
        load     = bus_io.reading && !reading_q;
        above_d  = load ? centre_q : above_q;
        centre_d = load ? bus_io.read_row : centre_q;
        col      = bus_io.column;
        active   = bus_io.display_active;
        wrap     = bus_io.wrap_edges;
        nxt_col  = (!active || col == COL_W'(WIDTH - 1)) ? '0 : col + 1'b1;
        nb       = {pick(from_left(above_q, wrap), nxt_col), pick(above_q, nxt_col),
                    pick(from_right(above_q, wrap), nxt_col), pick(from_left(centre_q, wrap), nxt_col),
                    pick(from_right(centre_q, wrap), nxt_col), pick(from_left(bus_io.read_row, wrap), nxt_col),
                    pick(bus_io.read_row, nxt_col), pick(from_right(bus_io.read_row, wrap), nxt_col)};
        count_d  = 4'($countones(nb));
        cur      = pick(centre_q, col);
        wbit     = state_q == CLEARING ? 1'b0 :
                   state_q == SEEDING  ? rand_w[7:0] < bus_io.density :
                   bus_io.freeze       ? cur :
                   cur ? bus_io.survive_mask[count_q] : bus_io.birth_mask[count_q];
        oh       = WIDTH'(1) << col;
        write_d  = active ? (write_q & ~oh) | (oh & {WIDTH{wbit}}) : write_q;
        pop_d    = active ? (col == '0 ? '0 : pop_q) + (COL_W + 1)'(wbit) : pop_q;
    end

    always_comb begin
        state_d      = state_q;
        clear_kind_d = clear_kind_q;
        if (state_q == IDLE && (bus_io.seed_request || bus_io.clear_request)) begin
            state_d      = ARMED;
            clear_kind_d = bus_io.clear_request;
        end else if (state_q == ARMED && bus_io.row == ROW_W'(ARM_ROW))
            state_d = clear_kind_q ? CLEARING : SEEDING;
        else if ((state_q == SEEDING || state_q == CLEARING) && bus_io.row == ROW_W'(LINES))
            state_d = IDLE;
    end

    always_ff @(posedge clkDiv or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            clear_kind_q <= 1'b0;
            reading_q    <= 1'b0;
            above_q      <= '0;
            centre_q     <= '0;
            write_q      <= '0;
            count_q      <= '0;
            pop_q        <= '0;
        end else begin
            state_q      <= state_d;
            clear_kind_q <= clear_kind_d;
            reading_q    <= bus_io.reading;
            above_q      <= above_d;
            centre_q     <= centre_d;
            write_q      <= write_d;
            count_q      <= count_d;
            pop_q        <= pop_d;
        end

    assign bus_io.draw_row  = centre_q;
    assign bus_io.write_row = write_q;
    assign bus_io.busy      = state_q != IDLE;
    assign bus_io.row_pop   = pop_q;
endmodule

// File: tb/tb_life_row_engine.sv
// tb_life_row_engine: random and directed generations checked against a per-cell Life reference
module tb_life_row_engine;
    import life_row_engine_pkg::*;
    localparam int W = 8, CW = 3, RW = 9, LN = 6, AR = 7;
    logic clkDiv = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    life_row_engine_if #(.WIDTH(W), .COL_W(CW), .ROW_W(RW)) bus ();
    life_row_engine #(.WIDTH(W), .COL_W(CW), .ROW_W(RW), .LINES(LN), .ARM_ROW(AR))
        dut (.clkDiv(clkDiv), .rst(rst), .bus_io(bus));

    always #5 clkDiv = ~clkDiv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int bit_at(input logic [W-1:0] v, input int j);
        return int'((v >> j) & W'(1));
    endfunction

    function automatic logic [W-1:0] life_ref(input logic [W-1:0] a, c, b, input logic [8:0] bm, sm,
                                              input logic wrap, frz);
        logic [W-1:0] nx;
        int n, j, live, r;
        nx = '0;
        for (int x = 0; x < W; x++) begin
            n = 0;
            for (int d = -1; d <= 1; d++) begin
                j = x + d;
                if (j < 0 || j >= W) begin
                    if (!wrap) continue;
                    j = (j + W) % W;
                end
                n += bit_at(a, j) + bit_at(b, j) + (d != 0 ? bit_at(c, j) : 0);
            end
            live = bit_at(c, x);
            r    = frz ? live : int'(((live != 0 ? sm : bm) >> n) & 9'd1);
            nx   = nx | (W'(r) << x);
        end
        return nx;
    endfunction

    task automatic tick();
        @(posedge clkDiv);
        #1;
        bus.noise = 1'($urandom);
    endtask

    task automatic load_row(input logic [W-1:0] r);
        bus.read_row = r;
        bus.reading  = 1'b1;
        tick();
        bus.reading  = 1'b0;
        tick();
    endtask

    task automatic run_row(input int r);
        bus.row            = RW'(r);
        bus.display_active = 1'b0;
        tick();
        tick();
        for (int c = 0; c < W; c++) begin
            bus.display_active = 1'b1;
            bus.column         = CW'(c);
            tick();
        end
        bus.display_active = 1'b0;
        bus.column         = '0;
        tick();
    endtask

    task automatic gen(input logic [W-1:0] a, c, b, input int r);
        logic [W-1:0] exp;
        load_row(a);
        load_row(c);
        bus.read_row = b;
        check("draw_row", 32'(bus.draw_row), 32'(c));
        run_row(r);
        exp = life_ref(a, c, b, bus.birth_mask, bus.survive_mask, bus.wrap_edges, bus.freeze);
        check("write_row", 32'(bus.write_row), 32'(exp));
        check("row_pop", 32'(bus.row_pop), 32'($countones(exp)));
    endtask

    task automatic request(input logic s, input logic c);
        bus.seed_request  = s;
        bus.clear_request = c;
        tick();
        bus.seed_request  = 1'b0;
        bus.clear_request = 1'b0;
        check("busy_armed", 32'(bus.busy), 32'd1);
    endtask

    task automatic frame(input logic zero_fill, output int total);
        total   = 0;
        bus.row = RW'(AR);
        tick();
        for (int r = 0; r < LN; r++) begin
            load_row(W'($urandom));
            load_row(W'($urandom));
            bus.read_row = W'($urandom);
            run_row(r);
            check("busy_frame", 32'(bus.busy), 32'd1);
            check("fill_pop", 32'(bus.row_pop), 32'($countones(bus.write_row)));
            if (zero_fill) check("fill_zero", 32'(bus.write_row), 32'd0);
            total += int'(bus.row_pop);
        end
        bus.row = RW'(LN);
        tick();
        bus.row = '0;
        tick();
        check("busy_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int total;
        bus.noise = 1'b0; bus.reading = 1'b0; bus.read_row = '0; bus.display_active = 1'b0;
        bus.row = '0; bus.column = '0; bus.wrap_edges = 1'b1; bus.freeze = 1'b0;
        bus.birth_mask = BIRTH_B3; bus.survive_mask = SURVIVE_S23;
        bus.seed_request = 1'b0; bus.clear_request = 1'b0; bus.density = 8'd0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_write", 32'(bus.write_row), 32'd0);
        check("rst_pop", 32'(bus.row_pop), 32'd0);
        check("rst_draw", 32'(bus.draw_row), 32'd0);
        rst = 1'b0;
        tick();

        gen(8'h00, 8'b00011100, 8'h00, 0);
        check("blinker", 32'(bus.write_row), 32'h08);
        check("blinker_pop", 32'(bus.row_pop), 32'd1);
        gen(8'h81, 8'h81, 8'h81, 0);
        bus.wrap_edges = 1'b0;
        gen(8'h81, 8'h81, 8'h81, 0);
        bus.freeze = 1'b1;
        gen(W'($urandom), 8'hA5, W'($urandom), 0);
        check("freeze", 32'(bus.write_row), 32'hA5);
        bus.freeze = 1'b0;

        for (int i = 0; i < 40; i++) begin
            bus.wrap_edges   = 1'($urandom);
            bus.freeze       = ($urandom_range(0, 7) == 0);
            bus.birth_mask   = i[0] ? 9'($urandom) : BIRTH_B3;
            bus.survive_mask = i[0] ? 9'($urandom) : SURVIVE_S23;
            gen(W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, LN - 1));
        end
        bus.freeze = 1'b0; bus.wrap_edges = 1'b1;
        bus.birth_mask = BIRTH_B3; bus.survive_mask = SURVIVE_S23;

        bus.density = 8'd0;
        request(1'b1, 1'b0);
        frame(1'b1, total);
        check("seed_empty", 32'(total), 32'd0);
        bus.density = 8'd255;
        request(1'b1, 1'b0);
        frame(1'b0, total);
        check("seed_dense", 32'(total >= LN * W - 6), 32'd1);
        request(1'b1, 1'b1);
        request(1'b1, 1'b0);
        frame(1'b1, total);
        check("clear_total", 32'(total), 32'd0);

        request(1'b1, 1'b0);
        bus.row = RW'(AR);
        tick();
        load_row(W'($urandom));
        load_row(W'($urandom));
        bus.row = RW'(2);
        for (int c = 0; c < 4; c++) begin
            bus.display_active = 1'b1;
            bus.column         = CW'(c);
            tick();
        end
        rst = 1'b1;
        tick();
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_write", 32'(bus.write_row), 32'd0);
        check("rst_mid_pop", 32'(bus.row_pop), 32'd0);
        bus.display_active = 1'b0;
        rst = 1'b0;
        tick();
        gen(8'h00, 8'h00, 8'h00, 3);
        check("after_rst_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
